// File: rtl/multicycle_ctrl_ws.sv
// multicycle_ctrl_ws: fetch/decode/execute controller for the 4-bit ISA
// with memory wait states, illegal-opcode trap, resumable halt and counters.
module multicycle_ctrl_ws #(
  parameter int CNT_W   = 16,
  parameter bit WAIT_EN = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       instr,
  input  logic             N,
  input  logic             Z,
  input  logic             mem_ready,
  input  logic             resume,
  input  logic             count_clr,
  output logic             PCwrite,
  output logic             AddrSel,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRload,
  output logic             R1Sel,
  output logic             MDRload,
  output logic             R1R2Load,
  output logic             ALU1,
  output logic             ALUOutWrite,
  output logic             RFWrite,
  output logic             RegIn,
  output logic             FlagWrite,
  output logic [2:0]       ALU2,
  output logic [2:0]       ALUop,
  output logic             halted,
  output logic             trap,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [4:0] {
    S_RST, S_F, S_D, S_ASN, S_WB, S_SH,
    S_ORI3, S_ORI4, S_ORI5, S_LD3, S_LD4, S_ST3,
    S_BPZ, S_BZ, S_BNZ, S_HALT, S_TRAP
  } state_t;

  state_t     state;
  state_t     nxt;
  logic [2:0] asn_op;
  logic [2:0] dec_op;
  logic       rdy;
  logic       retire;
  logic       run;

  assign rdy    = WAIT_EN ? mem_ready : 1'b1;
  assign run    = !(state inside {S_RST, S_HALT, S_TRAP});
  assign halted = (state == S_HALT);
  assign trap   = (state == S_TRAP);

  always_comb begin
    dec_op = 3'b000;
    if (instr == 4'b0110)
      dec_op = 3'b001;
    else if (instr == 4'b1000)
      dec_op = 3'b011;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= S_RST;
      asn_op <= 3'b000;
    end else begin
      state <= nxt;
      if (state == S_D)
        asn_op <= dec_op;
    end
  end

  // retire marks the edges that complete an instruction (incl. halt)
  always_comb begin
    nxt    = state;
    retire = 1'b0;
    unique case (state)
      S_RST: nxt = S_F;
      S_F:   if (rdy) nxt = S_D;
      S_D: begin
        if (instr == 4'b0100 || instr == 4'b0110 ||
            instr == 4'b1000)
          nxt = S_ASN;
        else if (instr[2:0] == 3'b011)
          nxt = S_SH;
        else if (instr[2:0] == 3'b111)
          nxt = S_ORI3;
        else if (instr == 4'b0000)
          nxt = S_LD3;
        else if (instr == 4'b0010)
          nxt = S_ST3;
        else if (instr == 4'b1101)
          nxt = S_BPZ;
        else if (instr == 4'b0101)
          nxt = S_BZ;
        else if (instr == 4'b1001)
          nxt = S_BNZ;
        else if (instr == 4'b1010) begin
          nxt    = S_F;
          retire = 1'b1;
        end else if (instr == 4'b0001) begin
          nxt    = S_HALT;
          retire = 1'b1;
        end else
          nxt = S_TRAP;
      end
      S_ASN, S_SH: nxt = S_WB;
      S_ORI3:      nxt = S_ORI4;
      S_ORI4:      nxt = S_ORI5;
      S_LD3:       if (rdy) nxt = S_LD4;
      S_ST3: begin
        if (rdy) begin
          nxt    = S_F;
          retire = 1'b1;
        end
      end
      S_WB, S_ORI5, S_LD4, S_BPZ, S_BZ, S_BNZ: begin
        nxt    = S_F;
        retire = 1'b1;
      end
      S_HALT, S_TRAP: if (resume) nxt = S_F;
      default: nxt = S_RST;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else if (count_clr) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (run && cycle_count != '1)
        cycle_count <= cycle_count + 1'b1;
      if (retire && instr_count != '1)
        instr_count <= instr_count + 1'b1;
    end
  end

  always_comb begin
    PCwrite     = 1'b0;
    AddrSel     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRload      = 1'b0;
    R1Sel       = 1'b0;
    MDRload     = 1'b0;
    R1R2Load    = 1'b0;
    ALU1        = 1'b0;
    ALUOutWrite = 1'b0;
    RFWrite     = 1'b0;
    RegIn       = 1'b0;
    FlagWrite   = 1'b0;
    ALU2        = 3'b000;
    ALUop       = 3'b000;
    unique case (state)
      S_F: begin
        AddrSel = 1'b1;
        MemRead = 1'b1;
        ALU2    = 3'b001;
        PCwrite = rdy;
        IRload  = rdy;
      end
      S_D: R1R2Load = 1'b1;
      S_ASN: begin
        ALU1        = 1'b1;
        ALUOutWrite = 1'b1;
        FlagWrite   = 1'b1;
        ALUop       = asn_op;
      end
      S_SH: begin
        ALU1        = 1'b1;
        ALU2        = 3'b100;
        ALUop       = 3'b100;
        ALUOutWrite = 1'b1;
        FlagWrite   = 1'b1;
      end
      S_WB: RFWrite = 1'b1;
      S_ORI3: begin
        R1Sel    = 1'b1;
        R1R2Load = 1'b1;
      end
      S_ORI4: begin
        ALU1        = 1'b1;
        ALU2        = 3'b011;
        ALUop       = 3'b010;
        ALUOutWrite = 1'b1;
        FlagWrite   = 1'b1;
      end
      S_ORI5: begin
        R1Sel   = 1'b1;
        RFWrite = 1'b1;
      end
      S_LD3: begin
        MemRead = 1'b1;
        MDRload = rdy;
      end
      S_LD4: begin
        ALUOutWrite = 1'b1;
        RFWrite     = 1'b1;
        RegIn       = 1'b1;
      end
      S_ST3: MemWrite = 1'b1;
      S_BPZ: begin
        ALU2    = 3'b010;
        PCwrite = ~N;
      end
      S_BZ: begin
        ALU2    = 3'b010;
        PCwrite = Z;
      end
      S_BNZ: begin
        ALU2    = 3'b010;
        PCwrite = ~Z;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl_ws.sv
// tb_multicycle_ctrl_ws: directed checks of the multicycle controller,
// with a CNT_W=2 instance alongside for counter saturation.
module tb_multicycle_ctrl_ws;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] instr = 4'b1010;
  logic       N = 1'b0;
  logic       Z = 1'b0;
  logic       mem_ready = 1'b1;
  logic       resume = 1'b0;
  logic       count_clr = 1'b0;

  logic PCwrite, AddrSel, MemRead, MemWrite, IRload, R1Sel, MDRload;
  logic R1R2Load, ALU1, ALUOutWrite, RFWrite, RegIn, FlagWrite;
  logic [2:0] ALU2, ALUop;
  logic halted, trap;
  logic [15:0] cycle_count, instr_count;

  logic PCwrite_b, AddrSel_b, MemRead_b, MemWrite_b, IRload_b, R1Sel_b;
  logic MDRload_b, R1R2Load_b, ALU1_b, ALUOutWrite_b, RFWrite_b;
  logic RegIn_b, FlagWrite_b;
  logic [2:0] ALU2_b, ALUop_b;
  logic halted_b, trap_b;
  logic [1:0] cyc_b, ins_b;

  logic [18:0] ctrl;
  int checks = 0;
  int failures = 0;
  int ecyc = 0;
  int eins = 0;

  localparam logic [18:0] B_PC  = 19'd1 << 18;
  localparam logic [18:0] B_AS  = 19'd1 << 17;
  localparam logic [18:0] B_MR  = 19'd1 << 16;
  localparam logic [18:0] B_MW  = 19'd1 << 15;
  localparam logic [18:0] B_IR  = 19'd1 << 14;
  localparam logic [18:0] B_R1  = 19'd1 << 13;
  localparam logic [18:0] B_MDR = 19'd1 << 12;
  localparam logic [18:0] B_RR  = 19'd1 << 11;
  localparam logic [18:0] B_A1  = 19'd1 << 10;
  localparam logic [18:0] B_AOW = 19'd1 << 9;
  localparam logic [18:0] B_RF  = 19'd1 << 8;
  localparam logic [18:0] B_RI  = 19'd1 << 7;
  localparam logic [18:0] B_FW  = 19'd1 << 6;

  localparam logic [18:0] E_F   = B_PC | B_AS | B_MR | B_IR | (19'd1 << 3);
  localparam logic [18:0] E_FW  = B_AS | B_MR | (19'd1 << 3);
  localparam logic [18:0] E_D   = B_RR;
  localparam logic [18:0] E_ADD = B_A1 | B_AOW | B_FW;
  localparam logic [18:0] E_SUB = E_ADD | 19'd1;
  localparam logic [18:0] E_NND = E_ADD | 19'd3;
  localparam logic [18:0] E_SH  = E_ADD | (19'd4 << 3) | 19'd4;
  localparam logic [18:0] E_WB  = B_RF;
  localparam logic [18:0] E_O3  = B_R1 | B_RR;
  localparam logic [18:0] E_O4  = E_ADD | (19'd3 << 3) | 19'd2;
  localparam logic [18:0] E_O5  = B_R1 | B_RF;
  localparam logic [18:0] E_L3  = B_MR;
  localparam logic [18:0] E_L3R = B_MR | B_MDR;
  localparam logic [18:0] E_L4  = B_AOW | B_RF | B_RI;
  localparam logic [18:0] E_ST  = B_MW;
  localparam logic [18:0] E_BR  = 19'd2 << 3;
  localparam logic [18:0] E_BRT = E_BR | B_PC;

  assign ctrl = {PCwrite, AddrSel, MemRead, MemWrite, IRload, R1Sel,
                 MDRload, R1R2Load, ALU1, ALUOutWrite, RFWrite, RegIn,
                 FlagWrite, ALU2, ALUop};

  multicycle_ctrl_ws #(.CNT_W(16), .WAIT_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .instr(instr), .N(N), .Z(Z),
    .mem_ready(mem_ready), .resume(resume), .count_clr(count_clr),
    .PCwrite(PCwrite), .AddrSel(AddrSel), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRload(IRload), .R1Sel(R1Sel),
    .MDRload(MDRload), .R1R2Load(R1R2Load), .ALU1(ALU1),
    .ALUOutWrite(ALUOutWrite), .RFWrite(RFWrite), .RegIn(RegIn),
    .FlagWrite(FlagWrite), .ALU2(ALU2), .ALUop(ALUop),
    .halted(halted), .trap(trap),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );

  multicycle_ctrl_ws #(.CNT_W(2), .WAIT_EN(1'b1)) dut_sat (
    .clock(clock), .reset(reset), .instr(instr), .N(N), .Z(Z),
    .mem_ready(mem_ready), .resume(resume), .count_clr(count_clr),
    .PCwrite(PCwrite_b), .AddrSel(AddrSel_b), .MemRead(MemRead_b),
    .MemWrite(MemWrite_b), .IRload(IRload_b), .R1Sel(R1Sel_b),
    .MDRload(MDRload_b), .R1R2Load(R1R2Load_b), .ALU1(ALU1_b),
    .ALUOutWrite(ALUOutWrite_b), .RFWrite(RFWrite_b), .RegIn(RegIn_b),
    .FlagWrite(FlagWrite_b), .ALU2(ALU2_b), .ALUop(ALUop_b),
    .halted(halted_b), .trap(trap_b),
    .cycle_count(cyc_b), .instr_count(ins_b)
  );

  always #5 clock = ~clock;

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); #1;
      checks++;
      if (ctrl !== 19'd0 || halted !== 1'b0 || trap !== 1'b0 ||
          cycle_count !== 16'd0 || instr_count !== 16'd0) begin
        failures++;
        $display("FAIL reset%0d ctrl=%h h=%b t=%b cyc=%0d ins=%0d exp all 0",
                 i, ctrl, halted, trap, cycle_count, instr_count);
      end
    end
    reset = 1'b1;
    @(negedge clock); #1;
    checks++;
    if (ctrl !== E_F || cycle_count !== 16'd0) begin
      failures++;
      $display("FAIL first_fetch ctrl=%h exp=%h cyc=%0d exp 0",
               ctrl, E_F, cycle_count);
    end
  endtask

  task automatic test_alu();
    logic [3:0]  ops [3] = '{4'b0100, 4'b0110, 4'b1000};
    logic [18:0] ex  [3] = '{E_ADD, E_SUB, E_NND};
    logic [18:0] seq [4];
    for (int k = 0; k < 3; k++) begin
      instr = ops[k];
      seq = '{E_D, ex[k], E_WB, E_F};
      for (int i = 0; i < 4; i++) begin
        @(negedge clock); #1;
        checks++;
        if (ctrl !== seq[i]) begin
          failures++;
          $display("FAIL alu op=%b cyc%0d ctrl=%h exp=%h",
                   ops[k], i, ctrl, seq[i]);
        end
      end
      ecyc += 4;
      eins += 1;
      checks++;
      if (cycle_count !== 16'(ecyc) || instr_count !== 16'(eins)) begin
        failures++;
        $display("FAIL alu_cnt op=%b cyc=%0d ins=%0d exp %0d %0d",
                 ops[k], cycle_count, instr_count, ecyc, eins);
      end
    end
  endtask

  task automatic test_load();
    logic [18:0] seq [6] = '{E_D, E_L3, E_L3, E_L3R, E_L4, E_F};
    logic        mr  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    instr = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      mem_ready = mr[i];
      #1;
      checks++;
      if (ctrl !== seq[i]) begin
        failures++;
        $display("FAIL load cyc%0d ctrl=%h exp=%h", i, ctrl, seq[i]);
      end
    end
    ecyc += 6;
    eins += 1;
    checks++;
    if (cycle_count !== 16'(ecyc) || instr_count !== 16'(eins)) begin
      failures++;
      $display("FAIL load_cnt cyc=%0d ins=%0d exp %0d %0d",
               cycle_count, instr_count, ecyc, eins);
    end
  endtask

  task automatic test_store();
    logic [18:0] seq [4] = '{E_D, E_ST, E_ST, E_F};
    logic        mr  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    instr = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      mem_ready = mr[i];
      #1;
      checks++;
      if (ctrl !== seq[i]) begin
        failures++;
        $display("FAIL store cyc%0d ctrl=%h exp=%h", i, ctrl, seq[i]);
      end
    end
    ecyc += 4;
    eins += 1;
  endtask

  task automatic test_branch();
    logic [3:0] ops [4] = '{4'b0101, 4'b1001, 4'b1101, 4'b1101};
    logic       nv  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic       zv  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic       tk  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [18:0] ex;
    for (int k = 0; k < 4; k++) begin
      instr = ops[k];
      N = nv[k];
      Z = zv[k];
      for (int j = 0; j < 3; j++) begin
        @(negedge clock); #1;
        ex = (j == 0) ? E_D : (j == 1) ? (tk[k] ? E_BRT : E_BR) : E_F;
        checks++;
        if (ctrl !== ex) begin
          failures++;
          $display("FAIL branch op=%b cyc%0d ctrl=%h exp=%h",
                   ops[k], j, ctrl, ex);
        end
        if (k == 0 && j == 1) begin
          Z = 1'b1;
          #1;
          checks++;
          if (PCwrite !== 1'b1) begin
            failures++;
            $display("FAIL bz_follow PCwrite=%b exp 1", PCwrite);
          end
          Z = 1'b0;
          #1;
        end
      end
      ecyc += 3;
      eins += 1;
    end
    N = 1'b0;
    Z = 1'b0;
    checks++;
    if (cycle_count !== 16'(ecyc) || instr_count !== 16'(eins)) begin
      failures++;
      $display("FAIL branch_cnt cyc=%0d ins=%0d exp %0d %0d",
               cycle_count, instr_count, ecyc, eins);
    end
  endtask

  task automatic test_shift_ori();
    logic [3:0]  ops [4] = '{4'b1111, 4'b1011, 4'b0011, 4'b0111};
    logic [18:0] seq [5];
    int n;
    for (int k = 0; k < 4; k++) begin
      instr = ops[k];
      if (ops[k][2]) begin
        seq = '{E_D, E_O3, E_O4, E_O5, E_F};
        n = 5;
      end else begin
        seq = '{E_D, E_SH, E_WB, E_F, 19'd0};
        n = 4;
      end
      for (int i = 0; i < n; i++) begin
        @(negedge clock); #1;
        checks++;
        if (ctrl !== seq[i]) begin
          failures++;
          $display("FAIL path op=%b cyc%0d ctrl=%h exp=%h",
                   ops[k], i, ctrl, seq[i]);
        end
      end
      ecyc += n;
      eins += 1;
    end
  endtask

  task automatic test_fetch_wait();
    mem_ready = 1'b0;
    #1;
    checks++;
    if (ctrl !== E_FW) begin
      failures++;
      $display("FAIL fwait0 ctrl=%h exp=%h", ctrl, E_FW);
    end
    @(negedge clock); #1;
    checks++;
    if (ctrl !== E_FW) begin
      failures++;
      $display("FAIL fwait1 ctrl=%h exp=%h", ctrl, E_FW);
    end
    mem_ready = 1'b1;
    instr = 4'b1010;
    #1;
    checks++;
    if (ctrl !== E_F) begin
      failures++;
      $display("FAIL fwait_rdy ctrl=%h exp=%h", ctrl, E_F);
    end
    @(negedge clock); #1;
    @(negedge clock); #1;
    ecyc += 3;
    eins += 1;
    checks++;
    if (ctrl !== E_F || cycle_count !== 16'(ecyc) ||
        instr_count !== 16'(eins)) begin
      failures++;
      $display("FAIL fwait_end ctrl=%h cyc=%0d ins=%0d exp %h %0d %0d",
               ctrl, cycle_count, instr_count, E_F, ecyc, eins);
    end
  endtask

  task automatic test_trap();
    instr = 4'b1100;
    @(negedge clock); #1;
    ecyc += 2;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock); #1;
      checks++;
      if (trap !== 1'b1 || ctrl !== 19'd0 ||
          cycle_count !== 16'(ecyc) || instr_count !== 16'(eins)) begin
        failures++;
        $display("FAIL trap%0d t=%b ctrl=%h cyc=%0d ins=%0d exp 1 0 %0d %0d",
                 i, trap, ctrl, cycle_count, instr_count, ecyc, eins);
      end
    end
    resume = 1'b1;
    @(negedge clock); #1;
    resume = 1'b0;
    checks++;
    if (trap !== 1'b0 || ctrl !== E_F || cycle_count !== 16'(ecyc) ||
        instr_count !== 16'(eins)) begin
      failures++;
      $display("FAIL trap_resume t=%b ctrl=%h cyc=%0d ins=%0d exp 0 %h %0d %0d",
               trap, ctrl, cycle_count, instr_count, E_F, ecyc, eins);
    end
  endtask

  task automatic test_halt();
    instr = 4'b0001;
    @(negedge clock); #1;
    @(negedge clock); #1;
    ecyc += 2;
    eins += 1;
    checks++;
    if (halted !== 1'b1 || ctrl !== 19'd0 ||
        cycle_count !== 16'(ecyc) || instr_count !== 16'(eins)) begin
      failures++;
      $display("FAIL halt h=%b ctrl=%h cyc=%0d ins=%0d exp 1 0 %0d %0d",
               halted, ctrl, cycle_count, instr_count, ecyc, eins);
    end
    resume = 1'b1;
    @(negedge clock); #1;
    resume = 1'b0;
    checks++;
    if (halted !== 1'b0 || ctrl !== E_F || cycle_count !== 16'(ecyc)) begin
      failures++;
      $display("FAIL halt_resume h=%b ctrl=%h cyc=%0d exp 0 %h %0d",
               halted, ctrl, cycle_count, E_F, ecyc);
    end
  endtask

  task automatic test_count_clr();
    count_clr = 1'b1;
    instr = 4'b1010;
    @(negedge clock); #1;
    count_clr = 1'b0;
    checks++;
    if (ctrl !== E_D || cycle_count !== 16'd0 || instr_count !== 16'd0 ||
        cyc_b !== 2'd0 || ins_b !== 2'd0) begin
      failures++;
      $display("FAIL clr ctrl=%h cyc=%0d ins=%0d cb=%0d ib=%0d exp %h 0 0 0 0",
               ctrl, cycle_count, instr_count, cyc_b, ins_b, E_D);
    end
    @(negedge clock); #1;
    ecyc = 1;
    eins = 1;
    checks++;
    if (cycle_count !== 16'(ecyc) || instr_count !== 16'(eins)) begin
      failures++;
      $display("FAIL clr_after cyc=%0d ins=%0d exp %0d %0d",
               cycle_count, instr_count, ecyc, eins);
    end
  endtask

  task automatic test_saturate();
    instr = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock); #1;
      @(negedge clock); #1;
    end
    ecyc += 10;
    eins += 5;
    checks++;
    if (ins_b !== 2'd3 || cyc_b !== 2'd3 ||
        instr_count !== 16'(eins) || cycle_count !== 16'(ecyc)) begin
      failures++;
      $display("FAIL sat ib=%0d cb=%0d ins=%0d cyc=%0d exp 3 3 %0d %0d",
               ins_b, cyc_b, instr_count, cycle_count, eins, ecyc);
    end
    instr = 4'b0001;
    @(negedge clock); #1;
    @(negedge clock); #1;
    ecyc += 2;
    eins += 1;
    checks++;
    if (halted_b !== 1'b1 || cyc_b !== 2'd3 || ins_b !== 2'd3) begin
      failures++;
      $display("FAIL sat_halt h=%b cb=%0d ib=%0d exp 1 3 3",
               halted_b, cyc_b, ins_b);
    end
    @(negedge clock); #1;
    checks++;
    if (halted !== 1'b1 || cycle_count !== 16'(ecyc)) begin
      failures++;
      $display("FAIL halt_frozen h=%b cyc=%0d exp 1 %0d",
               halted, cycle_count, ecyc);
    end
    count_clr = 1'b1;
    @(negedge clock); #1;
    count_clr = 1'b0;
    checks++;
    if (cyc_b !== 2'd0 || ins_b !== 2'd0 || cycle_count !== 16'd0 ||
        halted !== 1'b1) begin
      failures++;
      $display("FAIL halt_clr cb=%0d ib=%0d cyc=%0d h=%b exp 0 0 0 1",
               cyc_b, ins_b, cycle_count, halted);
    end
    resume = 1'b1;
    @(negedge clock); #1;
    resume = 1'b0;
    checks++;
    if (ctrl !== E_F) begin
      failures++;
      $display("FAIL sat_resume ctrl=%h exp=%h", ctrl, E_F);
    end
  endtask

  task automatic test_reset_mid();
    instr = 4'b1111;
    @(negedge clock); #1;
    @(negedge clock); #1;
    @(negedge clock); #1;
    checks++;
    if (ctrl !== E_O4) begin
      failures++;
      $display("FAIL mid_ori4 ctrl=%h exp=%h", ctrl, E_O4);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (ctrl !== 19'd0 || halted !== 1'b0 || trap !== 1'b0 ||
        cycle_count !== 16'd0 || instr_count !== 16'd0) begin
      failures++;
      $display("FAIL mid_reset ctrl=%h h=%b t=%b cyc=%0d ins=%0d exp all 0",
               ctrl, halted, trap, cycle_count, instr_count);
    end
    @(negedge clock); #1;
    checks++;
    if (ctrl !== 19'd0) begin
      failures++;
      $display("FAIL reset_held ctrl=%h exp 0", ctrl);
    end
    reset = 1'b1;
    @(negedge clock); #1;
    checks++;
    if (ctrl !== E_F) begin
      failures++;
      $display("FAIL reset_refetch ctrl=%h exp=%h", ctrl, E_F);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch();
    test_shift_ori();
    test_fetch_wait();
    test_trap();
    test_halt();
    test_count_clr();
    test_saturate();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_ws.md
# multicycle_ctrl_ws

Parametrised successor to the multicycle processor control FSM. It sequences the datapath through fetch, decode and execute for the existing 4-bit-opcode ISA. Compared with the earlier controller, it adds memory wait-state handshaking, an illegal-opcode trap, a resumable halt, and saturating cycle and retired-instruction counters. It sits between the instruction register, flag register and memory port and drives every datapath control line.

## Interface
- `CNT_W`, default 16: width of both performance counters; must be ≥ 2.
- `WAIT_EN`, default 1: 1 makes memory states wait on `mem_ready`; 0 treats `mem_ready` as constant 1.
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `instr` in 4: opcode from the instruction register.
- `N`, `Z` in 1 each: flag register outputs.
- `mem_ready` in 1: memory has completed the current read or write this cycle.
- `resume` in 1: leave HALT or TRAP.
- `count_clr` in 1: synchronous clear of both counters.
- `PCwrite`, `AddrSel`, `MemRead`, `MemWrite`, `IRload`, `R1Sel`, `MDRload` out 1 each: datapath controls.
- `R1R2Load`, `ALU1`, `ALUOutWrite`, `RFWrite`, `RegIn`, `FlagWrite` out 1 each: datapath controls.
- `ALU2`, `ALUop` out 3 each: ALU operand-2 select and ALU operation.
- `halted` out 1: state is HALT.
- `trap` out 1: state is TRAP.
- `cycle_count` out `CNT_W`: running-cycle counter.
- `instr_count` out `CNT_W`: retired-instruction counter.

## Operation
- States: RST, F, D, ASN, WB, SH, ORI3, ORI4, ORI5, LD3, LD4, ST3, BPZ, BZ, BNZ, HALT, TRAP.
- Transitions:
  - RST→F.
  - F→D when `mem_ready`; otherwise stay in F.
  - D decodes `instr` as follows, in this priority:
    - 0100/0110/1000 → ASN
    - `instr[2:0]`=011 → SH
    - `instr[2:0]`=111 → ORI3
    - 0000 → LD3
    - 0010 → ST3
    - 1101 → BPZ
    - 0101 → BZ
    - 1001 → BNZ
    - 1010 → F (nop)
    - 0001 → HALT
    - anything else → TRAP
  - ASN→WB; SH→WB; WB→F.
  - ORI3→ORI4→ORI5→F.
  - LD3→LD4 when `mem_ready`, else stay; LD4→F.
  - ST3→F when `mem_ready`, else stay.
  - BPZ, BZ, BNZ → F.
  - HALT or TRAP → F when `resume`=1, else stay.
- Outputs: any control not listed below is 0.
  - F: `AddrSel`=1, `MemRead`=1, `ALU2`=001. `PCwrite`=`IRload`=`mem_ready`.
  - D: `R1R2Load`=1.
  - ASN: `ALU1`=1, `ALUOutWrite`=1, `FlagWrite`=1. `ALUop` is 000 for add, 001 for sub, 011 for nand.
  - SH: `ALU1`=1, `ALU2`=100, `ALUop`=100, `ALUOutWrite`=1, `FlagWrite`=1.
  - WB: `RFWrite`=1.
  - ORI3: `R1Sel`=1, `R1R2Load`=1.
  - ORI4: `ALU1`=1, `ALU2`=011, `ALUop`=010, `ALUOutWrite`=1, `FlagWrite`=1.
  - ORI5: `R1Sel`=1, `RFWrite`=1.
  - LD3: `MemRead`=1. `MDRload`=`mem_ready`.
  - LD4: `ALUOutWrite`=1, `RFWrite`=1, `RegIn`=1.
  - ST3: `MemWrite`=1, held until `mem_ready`.
  - BPZ/BZ/BNZ: `ALU2`=010. `PCwrite` is ~`N`, `Z`, ~`Z` respectively.
  - HALT, TRAP, RST: all controls 0.
- Output timing classes:
  - All outputs are Moore (decoded from state) except two groups, which are combinational from inputs.
  - The `mem_ready`-gated strobes: `PCwrite`/`IRload` in F and `MDRload` in LD3.
  - The branch `PCwrite`, which follows `N`/`Z`.
- `cycle_count`:
  - Increments by 1 every cycle the state is not RST, HALT or TRAP.
  - Saturates at 2^`CNT_W`−1; it never wraps.
- `instr_count`:
  - Increments by 1 on each retirement, saturating the same way.
  - A retirement is a transition into F from WB, ORI5, LD4, ST3, any branch state, or D on nop.
  - Halt counts as retired on entry to HALT.
  - TRAP entry does not count.
- `count_clr`: both counters go to 0 on the next edge. It has priority over increment in the same cycle.

## Timing
- Reset asserted (low): state=RST immediately.
  - All controls, `halted` and `trap` are 0; both counters are 0.
  - Outputs stay at these values while reset is held.
- First F is the cycle after reset deasserts.
- Reset mid-instruction aborts with no further strobes. Memory strobes drop asynchronously.
- Cycles per instruction when `mem_ready` is always 1:
  - ALU ops and shift: 4.
  - ORI: 5.
  - Load: 4.
  - Store and branches: 3.
  - Nop: 2.
- Each cycle with `mem_ready`=0 in F, LD3 or ST3 adds exactly one cycle. `MemRead`/`MemWrite` and `AddrSel` are held stable throughout.
- `WAIT_EN`=0: latencies are as above regardless of `mem_ready`.
- `resume` is sampled only in HALT or TRAP and ignored elsewhere. `resume` high on the cycle of HALT entry takes effect on the next edge, so HALT lasts at least 1 cycle.
- `halted` and `trap` are registered state decodes, so they are high from the cycle the state is entered.

## Test plan
- Reset low for 3 cycles, then high: all outputs 0 during reset; F on cycle 1 with `MemRead`=1, `AddrSel`=1, `ALU2`=001.
- add (0100) with `mem_ready`=1: states F,D,ASN,WB. `ALUop`=000 in ASN, `RFWrite`=1 in WB. `instr_count` goes 0→1 and `cycle_count`=4.
- load with `mem_ready` low for 2 cycles in LD3: `MDRload`=0 for 2 cycles then 1 for 1 cycle. Total 6 cycles; `MemRead` held high through all 3 LD3 cycles.
- bz with Z=0 then bnz with Z=0: `PCwrite`=0 in BZ and 1 in BNZ; each instruction takes 3 cycles.
- Opcode 1111 (ori, `instr[2:0]`=111) vs 1011 (shift, `instr[2:0]`=011) vs 0011 (shift): each follows its listed path. Opcode 1100 → TRAP with `trap`=1 and counters frozen; `resume` pulse → F on the next edge.
- `CNT_W`=2: run 5 nops → `instr_count` saturates at 3. Stop → `halted`=1 and `cycle_count` frozen. `count_clr` → both counters 0. Reset low mid-ORI4 → RST with all controls 0.
